// File: rtl/ticket_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ticket_pkg
// Purpose  : Shared ticket types, buffer-state encoding and pointer arithmetic.
// Revision : 1.0
// ============================================================================
package ticket_pkg;

  localparam int unsigned TKT_DATA_WIDTH = 68;
  localparam int unsigned TKT_ADDR_WIDTH = 4;

  typedef logic [TKT_DATA_WIDTH-1:0] ticket_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Modular difference of two wrap-bit pointers that are ptr_bits wide.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned ptr_bits);
    logic [31:0] mask;
    mask = (ptr_bits >= 32) ? '1 : ((32'd1 << ptr_bits) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ticket_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : ticket_skid_buf
// Purpose  : Two-entry head/tail buffer absorbing the ticket RAM read latency.
// Revision : 1.0
// ============================================================================
module ticket_skid_buf
  import ticket_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TKT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic [1:0]            cnt_o
);

  buf_state_e            state_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (capture_i) begin
            head_q  <= cap_data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (capture_i && pop_i) begin
            head_q <= cap_data_i;
          end else if (capture_i) begin
            tail_q  <= cap_data_i;
            state_q <= TWO;
          end else if (pop_i) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (pop_i) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign head_o  = head_q;
  assign valid_o = (state_q != EMPTY);
  assign cnt_o   = state_q;

  // The reader's issue throttle guarantees a full buffer never sees a capture.
  a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture_i && (state_q == TWO)));

endmodule
`default_nettype wire

// File: rtl/ticket_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : ticket_fifo_reader
// Purpose  : Ticket RAM read-side controller; counters under TICKET_FIFO_READER_STATS_EN.
// Revision : 1.0
// ============================================================================
module ticket_fifo_reader
  import ticket_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TKT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = TKT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] tkt_data,
  output logic                  tkt_valid,
  input  logic                  tkt_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH+1:0] fill_level,
  output logic [31:0]           stat_pop_cnt,
  output logic [31:0]           stat_stall_cnt
);

  localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
  localparam int unsigned FILL_W = ADDR_WIDTH + 2;

  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic              inflight_q;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ_after_pop;
  logic              pop;

  assign pop = tkt_valid & tkt_ready;

  // Never hold more than two tickets between the RAM output and the head.
  assign occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign ram_rd_en     = rst_n & ~flush & (wr_ptr != rd_ptr_q) & (occ_after_pop < 3'd2);

  assign rd_ptr_d = flush ? wr_ptr : rd_ptr_q + PTR_W'(ram_rd_en);
  assign fill_d   = flush ? '0
                  : FILL_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr_q), PTR_W))
                    + FILL_W'(inflight_q) + FILL_W'(buf_cnt) - FILL_W'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= ram_rd_en;
      fill_q     <= fill_d;
    end
  end

  ticket_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (inflight_q),
    .cap_data_i (ram_q),
    .pop_i      (pop),
    .flush_i    (flush),
    .head_o     (tkt_data),
    .valid_o    (tkt_valid),
    .cnt_o      (buf_cnt)
  );

  assign rd_ptr        = rd_ptr_q;
  assign ram_read_addr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign fill_level    = fill_q;

`ifdef TICKET_FIFO_READER_STATS_EN
  logic [31:0] pop_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && !flush && (pop_cnt_q != '1)) begin
        pop_cnt_q <= pop_cnt_q + 32'd1;
      end
      if (tkt_ready && !tkt_valid && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stat_pop_cnt   = pop_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_pop_cnt   = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
